packet_detector: RTL and testbench

Upstream stage of the reverse-backscatter path: qualifies the raw envelope-comparator input and produces `DEC_OUT`, the packet-present level that drives the `DEC_IN` input of `modulator`. It synchronises the asynchronous comparator output, rejects short bursts, and bridges short envelope dropouts. It ends a packet after a sustained gap or a length timeout, then enforces a hold-off before re-arming. Timing is at 20 MHz `CLK` (50 ns/cycle), so `DEC_OUT` rise latency is fixed and deterministic for the downstream 36/40 µs window.

---
 rtl/leggiero_rx_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/packet_detector.sv | 184 ++++++++++++++++++
 tb/tb_packet_detector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/leggiero_rx_pkg.sv
// Shared definitions for the reverse-backscatter receive path: state encodings,
// default timing constants at the 20 MHz system clock, and small helpers.
package leggiero_rx_pkg;

    localparam int DEF_CLK_NS  = 50;
    localparam int DEF_MIN_ON  = 160;
    localparam int DEF_GAP_MAX = 20;
    localparam int DEF_MAX_LEN = 40000;
    localparam int DEF_HOLDOFF = 40;

    // Downstream modulator decision windows (36 us / 40 us, in cycles minus one).
    localparam int MOD_WIN_36US = 719;
    localparam int MOD_WIN_40US = 799;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_QUALIFY = 3'd1;
    localparam logic [2:0] ST_ACTIVE  = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_QUALIFY = ST_QUALIFY,
        S_ACTIVE  = ST_ACTIVE,
        S_GAP     = ST_GAP,
        S_HOLDOFF = ST_HOLDOFF,
        S_LOCKOUT = ST_LOCKOUT
    } pd_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous comparator outputs; both stages
// clear on a synchronous active-low reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/packet_detector.sv
// Qualifies the envelope-comparator output into a packet-present level with
// burst rejection, dropout bridging, length timeout and a re-arm hold-off.
module packet_detector
    import leggiero_rx_pkg::*;
#(
    parameter int MIN_ON  = DEF_MIN_ON,
    parameter int GAP_MAX = DEF_GAP_MAX,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        EN,
    input  logic        ENV_IN,
    output logic        DEC_OUT,
    output logic        PKT_DONE,
    output logic        PKT_TIMEOUT,
    output logic [15:0] PKT_LEN,
    output logic [15:0] PKT_CNT,
    output logic [2:0]  o_dbg_state
);

    localparam logic [15:0] MIN_ON_LAST  = 16'(MIN_ON - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_MAX - 1);
    localparam logic [15:0] LEN_LIMIT    = 16'(MAX_LEN);
    localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF - 1);

    logic w_env_s;

    sync_2ff u_sync (
        .i_clk   (CLK),
        .i_rst_n (rst_n),
        .i_d     (ENV_IN),
        .o_q     (w_env_s)
    );

    pd_state_t   r_state,   w_state_nxt;
    logic [15:0] r_cnt,     w_cnt_nxt;
    logic [15:0] r_gap,     w_gap_nxt;
    logic [15:0] r_len,     w_len_nxt;
    logic [15:0] r_pkt_len, w_pkt_len_nxt;
    logic [15:0] r_pkt_cnt, w_pkt_cnt_nxt;
    logic        r_dec,     w_dec_nxt;
    logic        r_done,    w_done_nxt;
    logic        r_timeout, w_timeout_nxt;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_gap     <= 16'd0;
            r_len     <= 16'd0;
            r_pkt_len <= 16'd0;
            r_pkt_cnt <= 16'd0;
            r_dec     <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap     <= w_gap_nxt;
            r_len     <= w_len_nxt;
            r_pkt_len <= w_pkt_len_nxt;
            r_pkt_cnt <= w_pkt_cnt_nxt;
            r_dec     <= w_dec_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_gap_nxt     = r_gap;
        w_len_nxt     = r_len;
        w_pkt_len_nxt = r_pkt_len;
        w_pkt_cnt_nxt = r_pkt_cnt;
        w_dec_nxt     = r_dec;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;

        if (!EN) begin
            // Disable abandons any packet silently; the statistics survive.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
            w_gap_nxt   = 16'd0;
            w_len_nxt   = 16'd0;
            w_dec_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = 16'd0;
                    w_gap_nxt = 16'd0;
                    w_len_nxt = 16'd0;
                    w_dec_nxt = 1'b0;
                    if (w_env_s) begin
                        w_state_nxt = S_QUALIFY;
                        w_cnt_nxt   = 16'd1;
                    end
                end

                S_QUALIFY: begin
                    if (!w_env_s) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 16'd0;
                    end else if (r_cnt == MIN_ON_LAST) begin
                        w_state_nxt = S_ACTIVE;
                        w_dec_nxt   = 1'b1;
                        w_len_nxt   = 16'd1;
                        w_cnt_nxt   = 16'd0;
                        w_gap_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end

                S_ACTIVE, S_GAP: begin
                    // The length limit wins over every other exit, including gap end.
                    if (r_len == LEN_LIMIT) begin
                        w_state_nxt   = S_LOCKOUT;
                        w_dec_nxt     = 1'b0;
                        w_timeout_nxt = 1'b1;
                        w_len_nxt     = 16'd0;
                        w_gap_nxt     = 16'd0;
                    end else if (r_state == S_GAP && !w_env_s && r_gap == GAP_LAST) begin
                        w_state_nxt   = S_HOLDOFF;
                        w_dec_nxt     = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_pkt_len_nxt = r_len;
                        w_pkt_cnt_nxt = sat_inc16(r_pkt_cnt);
                        w_len_nxt     = 16'd0;
                        w_gap_nxt     = 16'd0;
                        w_cnt_nxt     = 16'd0;
                    end else begin
                        w_len_nxt = r_len + 16'd1;
                        if (r_state == S_ACTIVE) begin
                            if (!w_env_s) begin
                                w_state_nxt = S_GAP;
                                w_gap_nxt   = 16'd1;
                            end
                        end else if (w_env_s) begin
                            w_state_nxt = S_ACTIVE;
                            w_gap_nxt   = 16'd0;
                        end else begin
                            w_gap_nxt = r_gap + 16'd1;
                        end
                    end
                end

                S_LOCKOUT: begin
                    if (!w_env_s) begin
                        w_state_nxt = S_HOLDOFF;
                        w_cnt_nxt   = 16'd0;
                    end
                end

                S_HOLDOFF: begin
                    if (r_cnt == HOLDOFF_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_gap_nxt   = 16'd0;
                    w_len_nxt   = 16'd0;
                    w_dec_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign DEC_OUT     = r_dec;
    assign PKT_DONE    = r_done;
    assign PKT_TIMEOUT = r_timeout;
    assign PKT_LEN     = r_pkt_len;
    assign PKT_CNT     = r_pkt_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_packet_detector.sv
// Bench for packet_detector: expected packet-end records are queued as the
// envelope is driven and compared against records captured on each end pulse.
module tb_packet_detector;

    localparam int W = 67;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        env_in;
    logic        dec_out;
    logic        pkt_done;
    logic        pkt_timeout;
    logic [15:0] pkt_len;
    logic [15:0] pkt_cnt;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc       = 0;
    int t_ref     = 0;
    int last_rise = 0;
    int rise_cnt  = 0;
    int done_cyc  = 0;
    int to_cyc    = 0;
    logic prev_dec = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    packet_detector dut (
        .CLK         (clk),
        .rst_n       (rst_n),
        .EN          (en),
        .ENV_IN      (env_in),
        .DEC_OUT     (dec_out),
        .PKT_DONE    (pkt_done),
        .PKT_TIMEOUT (pkt_timeout),
        .PKT_LEN     (pkt_len),
        .PKT_CNT     (pkt_cnt),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #25 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record layout: {timeout, done, dec_out, rise_off, fall_off, pkt_len, pkt_cnt}
    always @(negedge clk) begin
        if (dec_out === 1'b1 && prev_dec !== 1'b1) begin
            last_rise = cyc;
            rise_cnt  = rise_cnt + 1;
        end
        if (pkt_done === 1'b1) done_cyc = done_cyc + 1;
        if (pkt_timeout === 1'b1) to_cyc = to_cyc + 1;
        if (pkt_done === 1'b1 || pkt_timeout === 1'b1)
            obs_q.push_back({pkt_timeout, pkt_done, dec_out, 16'(last_rise - t_ref),
                             16'(cyc - t_ref), pkt_len, pkt_cnt});
        prev_dec = dec_out;
    end

    function automatic logic [W-1:0] mk_exp(input logic [1:0] kind, input int rise,
                                             input int fall, input int len, input int cnt);
        return {kind, 1'b0, 16'(rise), 16'(fall), 16'(len), 16'(cnt)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_env();
        @(negedge clk);
        env_in = 1'b1;
        t_ref  = cyc + 1;
    endtask

    task automatic hold_high(input int h);
        start_env();
        repeat (h) @(negedge clk);
        env_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int base;
        rst_n = 1'b0; en = 1'b1; env_in = 1'b1;
        wait_cyc(5);
        n_cmp++; if (dec_out !== 1'b0) begin n_bad++; $display("FAIL reset_dec got %b exp 0", dec_out); end
        n_cmp++; if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", pkt_done); end
        n_cmp++; if (pkt_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b exp 0", pkt_timeout); end
        n_cmp++; if (pkt_len !== 16'd0) begin n_bad++; $display("FAIL reset_len got %0d exp 0", pkt_len); end
        n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", pkt_cnt); end
        n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        base = rise_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        t_ref = cyc + 1;
        wait_cyc(159);
        n_cmp++; if (dec_out !== 1'b0 || rise_cnt !== base) begin
            n_bad++; $display("FAIL early_rise dec %b rises %0d exp dec 0 rises %0d", dec_out, rise_cnt, base);
        end
        wait_cyc(5);
        n_cmp++; if (rise_cnt !== base + 1 || last_rise - t_ref !== 161) begin
            n_bad++; $display("FAIL rise_latency got %0d exp 161", last_rise - t_ref);
        end
        @(negedge clk);
        rst_n = 1'b0; env_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (dec_out !== 1'b0) begin n_bad++; $display("FAIL reset_mid_dec got %b exp 0", dec_out); end
        wait_cyc(10);
    endtask

    task automatic test_short_burst();
        int base;
        base = rise_cnt;
        hold_high(159);
        wait_cyc(100);
        n_cmp++; if (rise_cnt !== base) begin n_bad++; $display("FAIL short_rise got %0d exp %0d", rise_cnt, base); end
        n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL short_cnt got %0d exp 0", pkt_cnt); end
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL short_pulse got %0d records exp 0", obs_q.size()); end
    endtask

    task automatic test_long_packet();
        logic [W-1:0] e, o;
        int d0;
        d0 = done_cyc;
        exp_q.push_back(mk_exp(2'b01, 161, 1021, 860, 1));
        hold_high(1000);
        wait_cyc(100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL long_pkt missing exp %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL long_pkt got %h exp %h", o, e); end end
        end
        n_cmp++; if (done_cyc - d0 !== 1) begin n_bad++; $display("FAIL long_done_width got %0d exp 1", done_cyc - d0); end
    endtask

    task automatic test_gap();
        logic [W-1:0] e, o;
        // 19-sample dropout is bridged
        exp_q.push_back(mk_exp(2'b01, 161, 740, 579, 2));
        start_env();
        repeat (400) @(negedge clk);
        env_in = 1'b0;
        repeat (19) @(negedge clk);
        env_in = 1'b1;
        repeat (300) @(negedge clk);
        env_in = 1'b0;
        wait_cyc(100);
        // 20-sample dropout ends the packet; the second burst re-qualifies after hold-off
        exp_q.push_back(mk_exp(2'b01, 161, 321, 160, 3));
        exp_q.push_back(mk_exp(2'b01, 521, 641, 120, 4));
        start_env();
        repeat (300) @(negedge clk);
        env_in = 1'b0;
        repeat (20) @(negedge clk);
        env_in = 1'b1;
        repeat (300) @(negedge clk);
        env_in = 1'b0;
        wait_cyc(100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL gap_pkt missing exp %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL gap_pkt got %h exp %h", o, e); end end
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] e, o;
        int r0, t0c;
        r0 = rise_cnt; t0c = to_cyc;
        exp_q.push_back(mk_exp(2'b10, 161, 40161, 120, 4));
        hold_high(50000);
        n_cmp++; if (rise_cnt !== r0 + 1 || dec_out !== 1'b0) begin
            n_bad++; $display("FAIL lockout_retrigger rises %0d dec %b exp rises %0d dec 0", rise_cnt - r0, dec_out, 1);
        end
        n_cmp++; if (to_cyc - t0c !== 1) begin n_bad++; $display("FAIL timeout_width got %0d exp 1", to_cyc - t0c); end
        wait_cyc(10);
        exp_q.push_back(mk_exp(2'b01, 191, 321, 130, 5));
        hold_high(300);
        wait_cyc(100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL timeout_pkt missing exp %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL timeout_pkt got %h exp %h", o, e); end end
        end
    endtask

    task automatic test_en_drop();
        int d0, t0c;
        start_env();
        repeat (661) @(negedge clk);
        d0 = done_cyc; t0c = to_cyc;
        en = 1'b0;
        @(negedge clk);
        n_cmp++; if (dec_out !== 1'b0) begin n_bad++; $display("FAIL en_dec got %b exp 0", dec_out); end
        n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL en_state got %0d exp 0", dbg_state); end
        n_cmp++; if (pkt_cnt !== 16'd5) begin n_bad++; $display("FAIL en_cnt got %0d exp 5", pkt_cnt); end
        n_cmp++; if (pkt_len !== 16'd130) begin n_bad++; $display("FAIL en_len got %0d exp 130", pkt_len); end
        wait_cyc(5);
        env_in = 1'b0;
        wait_cyc(5);
        en = 1'b1;
        wait_cyc(50);
        n_cmp++; if (done_cyc !== d0 || to_cyc !== t0c) begin
            n_bad++; $display("FAIL en_pulses done %0d to %0d exp 0 0", done_cyc - d0, to_cyc - t0c);
        end
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL en_records got %0d exp 0", obs_q.size()); end
    endtask

    task automatic test_rst_mid();
        start_env();
        wait_cyc(200);
        n_cmp++; if (dec_out !== 1'b1) begin n_bad++; $display("FAIL rst_mid_active got %b exp 1", dec_out); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_mid_cnt got %0d exp 0", pkt_cnt); end
        n_cmp++; if (pkt_len !== 16'd0) begin n_bad++; $display("FAIL rst_mid_len got %0d exp 0", pkt_len); end
        n_cmp++; if (dec_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_dec got %b exp 0", dec_out); end
        rst_n = 1'b1; env_in = 1'b0;
        wait_cyc(10);
    endtask

    initial begin
        test_reset();
        test_short_burst();
        test_long_packet();
        test_gap();
        test_timeout();
        test_en_drop();
        test_rst_mid();
        n_cmp++;
        if (obs_q.size() !== 0) begin n_bad++; $display("FAIL extra_records got %0d exp 0", obs_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
